// File: rtl/truth_table_sequencer.sv
// Truth-table demonstrator for F = WX | X~Y | W~Y: steps {W,X,Y} through 0..7
// on a prescaled tick or on button presses and drives an active-low 7-seg digit.

// One button chain: 2-flop synchronizer, stability counter, rising-edge event.
module tts_button #(
   parameter int DEB_CYCLES = 120000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic press
);
   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   logic [1:0]    sync;
   logic          level;
   logic          level_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync    <= '0;
         level   <= 1'b0;
         level_d <= 1'b0;
         cnt     <= '0;
      end else begin
         sync    <= {sync[0], raw};
         level_d <= level;
         // any cycle that agrees with the accepted level restarts the count
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEB_CYCLES - 1)) begin
            level <= sync[1];
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign press = level & ~level_d;
endmodule

module truth_table_sequencer #(
   parameter int TICK_DIV   = 12000000,
   parameter int DEB_CYCLES = 120000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_run,
   input  logic btn_step,
   input  logic mode,
   output logic W,
   output logic X,
   output logic Y,
   output logic F,
   output logic running,
   output logic sweep_done,
   output logic a,
   output logic b,
   output logic c,
   output logic d,
   output logic e,
   output logic f,
   output logic g
);
   localparam int NUM_BTN = 2;
   localparam int PW      = $clog2(TICK_DIV);

   typedef enum logic {PAUSED = 1'b0, RUNNING = 1'b1} state_t;

   state_t               state;
   state_t               state_nx;
   logic [NUM_BTN-1:0]   btn_raw;
   logic [NUM_BTN-1:0]   btn_ev;
   logic                 run_ev;
   logic                 step_ev;
   logic [PW-1:0]        pre;
   logic                 tick;
   logic                 pre_clr;
   logic                 pre_en;
   logic                 advance;
   logic [2:0]           idx;
   logic                 sweep_q;
   logic                 f_q;
   logic [6:0]           seg_q;

   function automatic logic f_of(input logic [2:0] i);
      return (i[2] & i[1]) | (i[1] & ~i[0]) | (i[2] & ~i[0]);
   endfunction

   // {a,b,c,d,e,f,g}, 0 = lit
   function automatic logic [6:0] seg_of(input logic [2:0] v);
      logic [6:0] s;
      case (v)
         3'd0:    s = 7'b0000001;
         3'd1:    s = 7'b1001111;
         3'd2:    s = 7'b0010010;
         3'd3:    s = 7'b0000110;
         3'd4:    s = 7'b1001100;
         3'd5:    s = 7'b0100100;
         3'd6:    s = 7'b0100000;
         default: s = 7'b0001111;
      endcase
      return s;
   endfunction

   assign btn_raw = {btn_step, btn_run};

   genvar i;
   generate
      for (i = 0; i < NUM_BTN; i++) begin : g_btn
         tts_button #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[i]),
            .press (btn_ev[i])
         );
      end
   endgenerate

   assign run_ev  = btn_ev[0];
   assign step_ev = btn_ev[1];
   assign tick    = (pre == PW'(TICK_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= PAUSED;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (run_ev) state_nx = (state == PAUSED) ? RUNNING : PAUSED;
   end

   // a run event always wins; a step while running is dropped
   always_comb begin
      pre_clr = 1'b0;
      pre_en  = 1'b0;
      advance = 1'b0;
      case (state)
         PAUSED: begin
            if (run_ev)       pre_clr = 1'b1;
            else if (step_ev) advance = 1'b1;
         end
         default: begin
            if (!run_ev) begin
               pre_en  = 1'b1;
               advance = tick;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre     <= '0;
         idx     <= 3'd0;
         sweep_q <= 1'b0;
      end else begin
         if (pre_clr)     pre <= '0;
         else if (pre_en) pre <= tick ? '0 : pre + 1'b1;
         if (advance) idx <= idx + 3'd1;
         sweep_q <= advance && (idx == 3'd7);
      end
   end

   // display stage trails the index by one register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f_q   <= 1'b0;
         seg_q <= 7'b0000001;
      end else begin
         f_q   <= f_of(idx);
         seg_q <= seg_of(mode ? idx : {2'b00, f_of(idx)});
      end
   end

   assign {W, X, Y}             = idx;
   assign F                     = f_q;
   assign running               = (state == RUNNING);
   assign sweep_done            = sweep_q;
   assign {a, b, c, d, e, f, g} = seg_q;
endmodule
